// File: rtl/hazard_ctrl.sv
// ---------------------------------------------------------------------------
// HazardCtrl: pipeline hazard controller for the 5-stage CPU.
//
// Watches the ID-stage source operands against a load sitting in EXE and
// inserts LOAD_LAT bubbles when a load result is needed too early. Squashes
// the wrong-path instructions when MEM resolves a taken branch/jump, and
// freezes every pipeline register while the shared memory port is busy.
// Two saturating counters record how often each event happened, for debug.
//
// Ports:
//   clk              rising-edge clock
//   rst              asynchronous active-high reset (also gates all outputs)
//   id_src_used      bit i set = ID instruction reads source operand i
//   id_src_idx       packed source indices, operand i at [i*IDX_W +: IDX_W]
//   exe_memread      EXE instruction is a load
//   exe_wb_en        EXE instruction writes a register
//   exe_wb_idx       EXE destination register index
//   mem_branch_taken branch/jump in MEM resolved taken
//   mem_busy         shared memory port busy
//   pc_stall         hold the PC
//   ifid_stall       hold IF/ID
//   idex_bubble      load a NOP into ID/EX
//   ifid_flush       clear IF/ID
//   idex_flush       clear ID/EX
//   exmem_flush      clear EX/MEM
//   freeze_all       hold every pipeline register
//   stall_events     load-use hazards detected (saturating)
//   flush_events     branch flushes performed (saturating)
// ---------------------------------------------------------------------------
module hazard_ctrl #(
    parameter int IDX_W    = 4,
    parameter int N_SRC    = 3,
    parameter int LOAD_LAT = 1,
    parameter int CNT_W    = 16
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [N_SRC-1:0]       id_src_used,
    input  logic [N_SRC*IDX_W-1:0] id_src_idx,
    input  logic                   exe_memread,
    input  logic                   exe_wb_en,
    input  logic [IDX_W-1:0]       exe_wb_idx,
    input  logic                   mem_branch_taken,
    input  logic                   mem_busy,
    output logic                   pc_stall,
    output logic                   ifid_stall,
    output logic                   idex_bubble,
    output logic                   ifid_flush,
    output logic                   idex_flush,
    output logic                   exmem_flush,
    output logic                   freeze_all,
    output logic [CNT_W-1:0]       stall_events,
    output logic [CNT_W-1:0]       flush_events
);

    typedef enum logic [1:0] {
        RUN       = 2'd0,
        LOAD_WAIT = 2'd1,
        FLUSH     = 2'd2
    } state_t;

    // Value loaded into lcnt when a hazard needs more than one bubble: the
    // first bubble is issued in RUN, the remaining LOAD_LAT-1 in LOAD_WAIT.
    localparam logic [2:0] LAT_M1 = 3'(LOAD_LAT - 1);

    state_t     state, state_next;
    logic [2:0] lcnt, lcnt_next;
    logic       hit;
    logic       stall_inc;
    logic       flush_inc;

    // Load-use hazard: a load in EXE whose destination matches any source
    // operand that the ID instruction actually reads.
    always_comb begin
        hit = 1'b0;
        for (int i = 0; i < N_SRC; i++) begin
            if (id_src_used[i] && (id_src_idx[i*IDX_W +: IDX_W] == exe_wb_idx))
                hit = 1'b1;
        end
        hit = hit && exe_memread && exe_wb_en;
    end

    // Next-state and output decode. Priority is busy > branch > hazard.
    // While busy nothing advances, so a branch or hazard seen during busy is
    // simply acted on in the first idle cycle. A branch seen in FLUSH belongs
    // to an instruction that was just squashed and is ignored. Reset gates
    // every output so a reset arriving mid-stall produces no stray bubble.
    always_comb begin
        state_next  = state;
        lcnt_next   = lcnt;
        stall_inc   = 1'b0;
        flush_inc   = 1'b0;
        pc_stall    = 1'b0;
        ifid_stall  = 1'b0;
        idex_bubble = 1'b0;
        ifid_flush  = 1'b0;
        idex_flush  = 1'b0;
        exmem_flush = 1'b0;
        freeze_all  = 1'b0;

        if (rst) begin
            state_next = RUN;
            lcnt_next  = 3'd0;
        end else if (mem_busy) begin
            freeze_all = 1'b1;
        end else begin
            case (state)
                RUN, FLUSH: begin
                    state_next = RUN;
                    if ((state == RUN) && mem_branch_taken) begin
                        ifid_flush  = 1'b1;
                        idex_flush  = 1'b1;
                        exmem_flush = 1'b1;
                        flush_inc   = 1'b1;
                        state_next  = FLUSH;
                    end else if (hit) begin
                        pc_stall    = 1'b1;
                        ifid_stall  = 1'b1;
                        idex_bubble = 1'b1;
                        stall_inc   = 1'b1;
                        if (LOAD_LAT > 1) begin
                            lcnt_next  = LAT_M1;
                            state_next = LOAD_WAIT;
                        end
                    end
                end
                LOAD_WAIT: begin
                    if (mem_branch_taken) begin
                        ifid_flush  = 1'b1;
                        idex_flush  = 1'b1;
                        exmem_flush = 1'b1;
                        flush_inc   = 1'b1;
                        lcnt_next   = 3'd0;
                        state_next  = FLUSH;
                    end else begin
                        pc_stall    = 1'b1;
                        ifid_stall  = 1'b1;
                        idex_bubble = 1'b1;
                        lcnt_next   = lcnt - 3'd1;
                        if (lcnt == 3'd1)
                            state_next = RUN;
                    end
                end
                default: begin
                    state_next = RUN;
                    lcnt_next  = 3'd0;
                end
            endcase
        end
    end

    // State and bubble counter registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= RUN;
            lcnt  <= 3'd0;
        end else begin
            state <= state_next;
            lcnt  <= lcnt_next;
        end
    end

    // Debug event counters stick at all-ones instead of wrapping, so a
    // saturated value always means "at least this many".
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stall_events <= '0;
            flush_events <= '0;
        end else begin
            if (stall_inc && (stall_events != '1))
                stall_events <= stall_events + 1'b1;
            if (flush_inc && (flush_events != '1))
                flush_events <= flush_events + 1'b1;
        end
    end

endmodule

// File: tb/tb_hazard_ctrl.sv
// ---------------------------------------------------------------------------
// Testbench for hazard_ctrl. Three instances (LOAD_LAT = 1, 3, 5) share one
// set of inputs; each check looks at the instance relevant to that scenario.
// Control outputs are compared as a 7-bit vector:
//   {pc_stall, ifid_stall, idex_bubble, ifid_flush, idex_flush,
//    exmem_flush, freeze_all}
// ---------------------------------------------------------------------------
module tb_hazard_ctrl;

    localparam logic [6:0] C_NONE  = 7'b0000000;
    localparam logic [6:0] C_STALL = 7'b1110000;
    localparam logic [6:0] C_FLUSH = 7'b0001110;
    localparam logic [6:0] C_FRZ   = 7'b0000001;

    logic        clk;
    logic        rst;
    logic [2:0]  id_src_used;
    logic [11:0] id_src_idx;
    logic        exe_memread;
    logic        exe_wb_en;
    logic [3:0]  exe_wb_idx;
    logic        mem_branch_taken;
    logic        mem_busy;

    logic [6:0]  ctrl1, ctrl3, ctrl5;
    logic [15:0] se1, fe1, se3, fe3, se5, fe5;

    logic pc1, is1, ib1, if1, xf1, mf1, fz1;
    logic pc3, is3, ib3, if3, xf3, mf3, fz3;
    logic pc5, is5, ib5, if5, xf5, mf5, fz5;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [2:0]  used;
        logic [11:0] idx;
        logic        memread;
        logic        wb_en;
        logic [3:0]  wb_idx;
        logic        br;
        logic        busy;
        logic [6:0]  exp_ctrl;
        logic [15:0] exp_se;
        logic [15:0] exp_fe;
    } vec_t;

    vec_t vecs[$];

    hazard_ctrl #(.IDX_W(4), .N_SRC(3), .LOAD_LAT(1), .CNT_W(16)) u_lat1 (
        .clk(clk), .rst(rst), .id_src_used(id_src_used), .id_src_idx(id_src_idx),
        .exe_memread(exe_memread), .exe_wb_en(exe_wb_en), .exe_wb_idx(exe_wb_idx),
        .mem_branch_taken(mem_branch_taken), .mem_busy(mem_busy),
        .pc_stall(pc1), .ifid_stall(is1), .idex_bubble(ib1), .ifid_flush(if1),
        .idex_flush(xf1), .exmem_flush(mf1), .freeze_all(fz1),
        .stall_events(se1), .flush_events(fe1)
    );

    hazard_ctrl #(.IDX_W(4), .N_SRC(3), .LOAD_LAT(3), .CNT_W(16)) u_lat3 (
        .clk(clk), .rst(rst), .id_src_used(id_src_used), .id_src_idx(id_src_idx),
        .exe_memread(exe_memread), .exe_wb_en(exe_wb_en), .exe_wb_idx(exe_wb_idx),
        .mem_branch_taken(mem_branch_taken), .mem_busy(mem_busy),
        .pc_stall(pc3), .ifid_stall(is3), .idex_bubble(ib3), .ifid_flush(if3),
        .idex_flush(xf3), .exmem_flush(mf3), .freeze_all(fz3),
        .stall_events(se3), .flush_events(fe3)
    );

    hazard_ctrl #(.IDX_W(4), .N_SRC(3), .LOAD_LAT(5), .CNT_W(16)) u_lat5 (
        .clk(clk), .rst(rst), .id_src_used(id_src_used), .id_src_idx(id_src_idx),
        .exe_memread(exe_memread), .exe_wb_en(exe_wb_en), .exe_wb_idx(exe_wb_idx),
        .mem_branch_taken(mem_branch_taken), .mem_busy(mem_busy),
        .pc_stall(pc5), .ifid_stall(is5), .idex_bubble(ib5), .ifid_flush(if5),
        .idex_flush(xf5), .exmem_flush(mf5), .freeze_all(fz5),
        .stall_events(se5), .flush_events(fe5)
    );

    assign ctrl1 = {pc1, is1, ib1, if1, xf1, mf1, fz1};
    assign ctrl3 = {pc3, is3, ib3, if3, xf3, mf3, fz3};
    assign ctrl5 = {pc5, is5, ib5, if5, xf5, mf5, fz5};

    // Free-running clock, rising edges at 5, 15, 25, ...
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Compare one value and log a FAIL line on mismatch.
    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %0h expected %0h", name, actual, expected);
        end
    endtask

    // Drive all DUT inputs from one vector record.
    task automatic applyStimulus(input vec_t v);
        id_src_used      = v.used;
        id_src_idx       = v.idx;
        exe_memread      = v.memread;
        exe_wb_en        = v.wb_en;
        exe_wb_idx       = v.wb_idx;
        mem_branch_taken = v.br;
        mem_busy         = v.busy;
    endtask

    task automatic addVec(input logic [2:0] used, input logic [11:0] idx,
                          input logic memread, input logic wb_en,
                          input logic [3:0] wb_idx, input logic br,
                          input logic busy, input logic [6:0] exp_ctrl,
                          input logic [15:0] exp_se, input logic [15:0] exp_fe);
        vec_t v;
        v.used = used; v.idx = idx; v.memread = memread; v.wb_en = wb_en;
        v.wb_idx = wb_idx; v.br = br; v.busy = busy; v.exp_ctrl = exp_ctrl;
        v.exp_se = exp_se; v.exp_fe = exp_fe;
        vecs.push_back(v);
    endtask

    task automatic driveIdle();
        vec_t v;
        v.used = 3'b000; v.idx = 12'h000; v.memread = 1'b0; v.wb_en = 1'b0;
        v.wb_idx = 4'd0; v.br = 1'b0; v.busy = 1'b0; v.exp_ctrl = C_NONE;
        v.exp_se = 16'd0; v.exp_fe = 16'd0;
        applyStimulus(v);
    endtask

    task automatic driveHazard3();
        vec_t v;
        v.used = 3'b001; v.idx = 12'h003; v.memread = 1'b1; v.wb_en = 1'b1;
        v.wb_idx = 4'd3; v.br = 1'b0; v.busy = 1'b0; v.exp_ctrl = C_NONE;
        v.exp_se = 16'd0; v.exp_fe = 16'd0;
        applyStimulus(v);
    endtask

    // Pulse reset for one edge; leaves time at 1 unit after a rising edge.
    task automatic doReset();
        driveIdle();
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    task automatic nextCycle();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst = 1'b1;
        driveIdle();
        #2;
        checkOutput("reset_ctrl1", {25'd0, ctrl1}, {25'd0, C_NONE});
        checkOutput("reset_ctrl3", {25'd0, ctrl3}, {25'd0, C_NONE});
        checkOutput("reset_cnt3", {se3, fe3}, 32'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;

        // Sequence for the LOAD_LAT=3 instance; counts are values seen
        // during the cycle, before that cycle's edge.
        // H3: load into r3, ID reads r3 on src0.
        addVec(3'b001, 12'h003, 1, 1, 4'd3,  0, 0, C_STALL, 0, 0); // 0 hazard
        addVec(3'b000, 12'h000, 0, 0, 4'd0,  0, 0, C_STALL, 1, 0); // 1
        addVec(3'b000, 12'h000, 0, 0, 4'd0,  0, 0, C_STALL, 1, 0); // 2
        addVec(3'b000, 12'h000, 0, 0, 4'd0,  0, 0, C_NONE,  1, 0); // 3 done
        // SP hazard on store source (src2 = r10).
        addVec(3'b100, 12'hA00, 1, 1, 4'd10, 0, 0, C_STALL, 1, 0); // 4
        addVec(3'b000, 12'h000, 0, 0, 4'd0,  0, 0, C_STALL, 2, 0); // 5
        addVec(3'b000, 12'h000, 0, 0, 4'd0,  0, 0, C_STALL, 2, 0); // 6
        addVec(3'b000, 12'h000, 0, 0, 4'd0,  0, 0, C_NONE,  2, 0); // 7
        // Branch in RUN, held high: second cycle is FLUSH, ignored.
        addVec(3'b000, 12'h000, 0, 0, 4'd0,  1, 0, C_FLUSH, 2, 0); // 8
        addVec(3'b000, 12'h000, 0, 0, 4'd0,  1, 0, C_NONE,  2, 1); // 9
        addVec(3'b000, 12'h000, 0, 0, 4'd0,  0, 0, C_NONE,  2, 1); // 10
        // Branch during the 2nd bubble cancels the rest.
        addVec(3'b001, 12'h003, 1, 1, 4'd3,  0, 0, C_STALL, 2, 1); // 11
        addVec(3'b000, 12'h000, 0, 0, 4'd0,  1, 0, C_FLUSH, 3, 1); // 12
        addVec(3'b000, 12'h000, 0, 0, 4'd0,  0, 0, C_NONE,  3, 2); // 13
        addVec(3'b000, 12'h000, 0, 0, 4'd0,  0, 0, C_NONE,  3, 2); // 14
        // Busy for 4 cycles with a hazard pending.
        addVec(3'b001, 12'h003, 1, 1, 4'd3,  0, 1, C_FRZ,   3, 2); // 15
        addVec(3'b001, 12'h003, 1, 1, 4'd3,  1, 1, C_FRZ,   3, 2); // 16
        addVec(3'b001, 12'h003, 1, 1, 4'd3,  0, 1, C_FRZ,   3, 2); // 17
        addVec(3'b001, 12'h003, 1, 1, 4'd3,  0, 1, C_FRZ,   3, 2); // 18
        addVec(3'b001, 12'h003, 1, 1, 4'd3,  0, 0, C_STALL, 3, 2); // 19
        addVec(3'b000, 12'h000, 0, 0, 4'd0,  0, 0, C_STALL, 4, 2); // 20
        addVec(3'b000, 12'h000, 0, 0, 4'd0,  0, 0, C_STALL, 4, 2); // 21
        addVec(3'b000, 12'h000, 0, 0, 4'd0,  0, 0, C_NONE,  4, 2); // 22
        // Near misses: wrong index, not a load, no writeback, unused source.
        addVec(3'b001, 12'h004, 1, 1, 4'd3,  0, 0, C_NONE,  4, 2); // 23
        addVec(3'b001, 12'h003, 0, 1, 4'd3,  0, 0, C_NONE,  4, 2); // 24
        addVec(3'b001, 12'h003, 1, 0, 4'd3,  0, 0, C_NONE,  4, 2); // 25
        addVec(3'b110, 12'h003, 1, 1, 4'd3,  0, 0, C_NONE,  4, 2); // 26
        // Hazard in the FLUSH cycle is honoured; src1 match.
        addVec(3'b000, 12'h000, 0, 0, 4'd0,  1, 0, C_FLUSH, 4, 2); // 27
        addVec(3'b010, 12'h070, 1, 1, 4'd7,  1, 0, C_STALL, 4, 3); // 28
        addVec(3'b000, 12'h000, 0, 0, 4'd0,  0, 0, C_STALL, 5, 3); // 29
        addVec(3'b000, 12'h000, 0, 0, 4'd0,  0, 0, C_STALL, 5, 3); // 30
        addVec(3'b000, 12'h000, 0, 0, 4'd0,  0, 0, C_NONE,  5, 3); // 31

        for (int i = 0; i < vecs.size(); i++) begin
            applyStimulus(vecs[i]);
            #4;
            checkOutput($sformatf("lat3_ctrl[%0d]", i), {25'd0, ctrl3},
                        {25'd0, vecs[i].exp_ctrl});
            checkOutput($sformatf("lat3_cnt[%0d]", i), {se3, fe3},
                        {vecs[i].exp_se, vecs[i].exp_fe});
            nextCycle();
        end

        // LOAD_LAT=1: a single bubble, state stays in RUN.
        doReset();
        driveHazard3();
        #4;
        checkOutput("lat1_bubble", {25'd0, ctrl1}, {25'd0, C_STALL});
        nextCycle();
        driveIdle();
        #4;
        checkOutput("lat1_after", {25'd0, ctrl1}, {25'd0, C_NONE});
        checkOutput("lat1_stall_events", {16'd0, se1}, 32'd1);
        nextCycle();

        // Reset arriving in LOAD_WAIT (LOAD_LAT=5) leaves no residue.
        doReset();
        driveHazard3();
        #4;
        checkOutput("lat5_first", {25'd0, ctrl5}, {25'd0, C_STALL});
        nextCycle();
        driveIdle();
        #4;
        checkOutput("lat5_wait", {25'd0, ctrl5}, {25'd0, C_STALL});
        nextCycle();
        rst = 1'b1;
        #1;
        checkOutput("lat5_rst_ctrl", {25'd0, ctrl5}, {25'd0, C_NONE});
        checkOutput("lat5_rst_cnt", {se5, fe5}, 32'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        for (int i = 0; i < 6; i++) begin
            #4;
            checkOutput($sformatf("lat5_post_rst[%0d]", i), {25'd0, ctrl5},
                        {25'd0, C_NONE});
            nextCycle();
        end

        // Saturation: hold a hazard on LOAD_LAT=1, one count per cycle.
        doReset();
        driveHazard3();
        for (int i = 0; i < 65534; i++)
            nextCycle();
        checkOutput("sat_before", {16'd0, se1}, 32'h0000FFFE);
        nextCycle();
        checkOutput("sat_reached", {16'd0, se1}, 32'h0000FFFF);
        for (int i = 0; i < 5; i++)
            nextCycle();
        checkOutput("sat_hold", {16'd0, se1}, 32'h0000FFFF);
        driveIdle();
        nextCycle();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/hazard_ctrl.md
Name: hazard_ctrl

Overview:
- Parametrised pipeline hazard controller for the 5-stage CPU. Successor to the single-cycle bubble logic.
- Detects load-use hazards over N_SRC source operands, with a configurable load-to-use latency. Squashes wrong-path instructions on a taken branch/jump resolved in MEM. Freezes the whole pipe while the shared memory port is busy.
- Sits beside the pipeline registers and drives their stall/flush enables. Keeps saturating stall/flush event counters for debug.

Parameters:
- IDX_W, 4, register-index width (index 10 = SP in the default file).
- N_SRC, 3, number of ID-stage source operands checked (src1, src2, mem-store src).
- LOAD_LAT, 1, bubbles inserted per load-use hazard (1..7).
- CNT_W, 16, width of the event counters.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  asynchronous active-high reset.
- id_src_used  in  N_SRC  bit i = ID instruction reads source i.
- id_src_idx  in  N_SRC*IDX_W  packed source indices; source i occupies bits [i*IDX_W +: IDX_W].
- exe_memread  in  1  EXE instruction is a load.
- exe_wb_en  in  1  EXE instruction writes a register.
- exe_wb_idx  in  IDX_W  EXE destination index.
- mem_branch_taken  in  1  MEM-stage branch/jump resolved taken (zero && PCSrc != NEXT).
- mem_busy  in  1  shared memory port busy (RAM write / serial access).
- pc_stall  out  1  hold PC.
- ifid_stall  out  1  hold IF/ID.
- idex_bubble  out  1  load NOP into ID/EX.
- ifid_flush  out  1  clear IF/ID.
- idex_flush  out  1  clear ID/EX.
- exmem_flush  out  1  clear EX/MEM.
- freeze_all  out  1  hold every pipeline register.
- stall_events  out  CNT_W  load-use hazards detected, saturating.
- flush_events  out  CNT_W  branch flushes performed, saturating.

Behaviour:
- Hazard condition: hit = exe_memread && exe_wb_en && OR over i of (id_src_used[i] && id_src_idx[i] == exe_wb_idx).
- FSM states: RUN, LOAD_WAIT, FLUSH. Internal counter lcnt is 3 bits wide.
- Reset: while rst = 1 the state is RUN, lcnt = 0, both event counters = 0, and every output is 0 (the outputs are combinationally gated by rst). Reset may arrive mid-stall or mid-flush; the state aborts to RUN with no residual bubbles.
- Input priority, highest first: mem_busy > mem_branch_taken > hit.
- mem_busy = 1:
  - freeze_all = 1 and every other control output = 0.
  - State, lcnt and both counters hold.
  - A branch or hazard presented during busy is acted on in the first cycle mem_busy = 0.
- RUN:
  - If mem_branch_taken: ifid_flush = idex_flush = exmem_flush = 1 in the same cycle. flush_events increments. Next state is FLUSH.
  - Else if hit: pc_stall = ifid_stall = idex_bubble = 1 in the same cycle. stall_events increments. If LOAD_LAT > 1, lcnt <= LOAD_LAT-1 and next state is LOAD_WAIT; otherwise the state stays RUN.
  - Else all outputs are 0.
- LOAD_WAIT:
  - pc_stall = ifid_stall = idex_bubble = 1.
  - lcnt decrements each cycle; at lcnt = 1 the next state is RUN.
  - Total consecutive bubbles per hazard = LOAD_LAT exactly.
  - hit is not re-evaluated and not re-counted in this state.
  - mem_branch_taken in LOAD_WAIT wins: do the flush outputs above, clear lcnt, go to FLUSH, and increment flush_events.
- FLUSH:
  - One cycle with all outputs 0, so the fetch from the new PC proceeds. Next state is RUN.
  - mem_branch_taken here is ignored; it is a squashed instruction that has already been flushed.
  - A hit here is evaluated as in RUN.
- Counters saturate at all-ones and never wrap.
- All outputs are combinational functions of state, lcnt and the inputs. Zero cycles of latency from a hazard or branch to its control outputs.

Test Plan:
- LOAD_LAT=1: exe_memread=1, exe_wb_en=1, exe_wb_idx=3, id_src_used=001, src0 idx=3 -> pc_stall/ifid_stall/idex_bubble high for exactly 1 cycle; stall_events=1.
- LOAD_LAT=3: same hazard held for 1 cycle, inputs then cleared -> 3 consecutive bubble cycles, then 0; stall_events=1. Repeat with src2 idx=10 (SP) and exe_wb_idx=10 -> same result.
- mem_branch_taken=1 in RUN -> 3 flush outputs high for 1 cycle; next cycle all outputs 0 even if mem_branch_taken stays 1; flush_events=1.
- LOAD_LAT=3, branch in the 2nd bubble cycle -> flush outputs that cycle, no further bubbles, flush_events=1, stall_events=1.
- mem_busy=1 for 4 cycles together with a hit -> freeze_all=1 for 4 cycles, no bubble; bubbles start the cycle mem_busy falls.
- Pulse rst in LOAD_WAIT (LOAD_LAT=5) -> outputs 0 immediately, counters 0, no bubbles after release; 65535+ hazards -> stall_events stays 0xFFFF.
